// File: rtl/ctx_pkg.sv
// Shared types and constants for the context-switch unit: FSM state encoding,
// process-slot defaults and the selector packing helper.
package ctx_pkg;

    localparam int NUM_PROC_DEF = 11;
    localparam int PID_W        = 4;
    localparam int DATA_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_BASE  = 3'd2,
        ST_ENTER = 3'd3,
        ST_RUN   = 3'd4,
        ST_EXIT  = 3'd5
    } state_e;

    function automatic logic [DATA_W-1:0] pid_to_sel(input logic [PID_W-1:0] pid);
        return {{(DATA_W-PID_W){1'b0}}, pid};
    endfunction

endpackage

// File: rtl/ctx_switch_unit_if.sv
// Kernel-side request bus and MMU/mode-control outputs of the context-switch unit.
interface ctx_switch_unit_if #(
    parameter int QW = 16
);
    import ctx_pkg::*;

    logic                req;
    logic [PID_W-1:0]    pid;
    logic [DATA_W-1:0]   base;
    logic                load_base;
    logic [QW-1:0]       quantum;
    logic                inta;
    logic                sys_exit;

    logic [DATA_W-1:0]   sel;
    logic [DATA_W-1:0]   offset;
    logic                we_sel;
    logic                we_addr;
    logic                userMode;
    logic                kernelMode;
    logic                busy;
    logic                ack;
    logic                err;
    logic                preempt;
    logic [PID_W-1:0]    cur_pid;

    modport master (
        output req, pid, base, load_base, quantum, inta, sys_exit,
        input  sel, offset, we_sel, we_addr, userMode, kernelMode,
               busy, ack, err, preempt, cur_pid
    );

    modport slave (
        input  req, pid, base, load_base, quantum, inta, sys_exit,
        output sel, offset, we_sel, we_addr, userMode, kernelMode,
               busy, ack, err, preempt, cur_pid
    );

endinterface

// File: rtl/quantum_timer.sv
// Time-slice down-counter: loads a quantum, decrements while enabled and
// saturates at zero; expired_o flags the cycle in which it steps 1 -> 0.
module quantum_timer #(
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          enable_i,
    input  logic [QW-1:0] quantum_i,
    output logic          expired_o
);

    logic [QW-1:0] count_q;
    logic [QW-1:0] count_d;

    // Next count: load has priority, then saturating decrement
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = quantum_i;
        end else if (enable_i && (count_q != {QW{1'b0}})) begin
            count_d = count_q - QW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {QW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == QW'(1));

endmodule

// File: rtl/ctx_switch_unit.sv
// Context-switch sequencer: programs the MMU selector/base for a process slot,
// enters user mode, enforces the time quantum and returns control to the kernel.
module ctx_switch_unit
    import ctx_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int QW       = 16
) (
    input  logic             clk,
    input  logic             reset,
    ctx_switch_unit_if.slave bus
);

    localparam logic [PID_W:0] PID_LIMIT = (PID_W+1)'(NUM_PROC);

    state_e              state_q, state_d;
    logic [PID_W-1:0]    cur_pid_q, cur_pid_d;
    logic [DATA_W-1:0]   base_q, base_d;
    logic                load_base_q, load_base_d;
    logic [QW-1:0]       quantum_q, quantum_d;
    logic [DATA_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]   offset_q, offset_d;
    logic                we_sel_q, we_sel_d;
    logic                we_addr_q, we_addr_d;
    logic                user_mode_q, user_mode_d;
    logic                kernel_mode_q, kernel_mode_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                preempt_q, preempt_d;

    logic                accept_s;
    logic                reject_s;
    logic                exit_s;
    logic                timer_load_s;
    logic                timer_en_s;
    logic                timer_expired_s;

    assign timer_load_s = (state_q == ST_ENTER);
    assign timer_en_s   = (state_q == ST_RUN);

    quantum_timer #(
        .QW (QW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timer_load_s),
        .enable_i  (timer_en_s),
        .quantum_i (quantum_q),
        .expired_o (timer_expired_s)
    );

    // Next state plus next values of every output register
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        reject_s = 1'b0;
        exit_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if ({1'b0, bus.pid} < PID_LIMIT) begin
                        accept_s = 1'b1;
                        state_d  = ST_SEL;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (load_base_q) begin
                    state_d = ST_BASE;
                end else begin
                    state_d = ST_ENTER;
                end
            end
            ST_BASE:  state_d = ST_ENTER;
            ST_ENTER: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.inta || bus.sys_exit) begin
                    exit_s  = 1'b1;
                    state_d = ST_EXIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_EXIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            cur_pid_d   = bus.pid;
            base_d      = bus.base;
            load_base_d = bus.load_base;
            quantum_d   = bus.quantum;
            sel_d       = pid_to_sel(bus.pid);
        end else begin
            cur_pid_d   = cur_pid_q;
            base_d      = base_q;
            load_base_d = load_base_q;
            quantum_d   = quantum_q;
            sel_d       = sel_q;
        end

        if (state_d == ST_BASE) begin
            offset_d = base_q;
        end else begin
            offset_d = offset_q;
        end

        // Leaving RUN beats a simultaneous expiry, so preempt never rises then
        if (exit_s) begin
            preempt_d = 1'b0;
        end else if (timer_expired_s) begin
            preempt_d = 1'b1;
        end else begin
            preempt_d = preempt_q;
        end

        we_sel_d      = (state_d == ST_SEL);
        we_addr_d     = (state_d == ST_BASE);
        user_mode_d   = (state_d == ST_ENTER);
        kernel_mode_d = (state_d == ST_EXIT);
        busy_d        = (state_d != ST_IDLE);
        err_d         = reject_s;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_pid_q     <= {PID_W{1'b0}};
            base_q        <= {DATA_W{1'b0}};
            load_base_q   <= 1'b0;
            quantum_q     <= {QW{1'b0}};
            sel_q         <= {DATA_W{1'b0}};
            offset_q      <= {DATA_W{1'b0}};
            we_sel_q      <= 1'b0;
            we_addr_q     <= 1'b0;
            user_mode_q   <= 1'b0;
            kernel_mode_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_pid_q     <= cur_pid_d;
            base_q        <= base_d;
            load_base_q   <= load_base_d;
            quantum_q     <= quantum_d;
            sel_q         <= sel_d;
            offset_q      <= offset_d;
            we_sel_q      <= we_sel_d;
            we_addr_q     <= we_addr_d;
            user_mode_q   <= user_mode_d;
            kernel_mode_q <= kernel_mode_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            preempt_q     <= preempt_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.offset     = offset_q;
    assign bus.we_sel     = we_sel_q;
    assign bus.we_addr    = we_addr_q;
    assign bus.userMode   = user_mode_q;
    assign bus.kernelMode = kernel_mode_q;
    assign bus.busy       = busy_q;
    assign bus.ack        = user_mode_q;
    assign bus.err        = err_q;
    assign bus.preempt    = preempt_q;
    assign bus.cur_pid    = cur_pid_q;

endmodule

// File: tb/tb_ctx_switch_unit.sv
// Directed bench for ctx_switch_unit: a per-cycle expected-output timeline is
// built from each transaction's rules and compared against the DUT every cycle.
module tb_ctx_switch_unit;
    import ctx_pkg::*;

    localparam int QW = 16;
    localparam int N  = 4096;

    localparam int F_WSEL  = 0;
    localparam int F_WADDR = 1;
    localparam int F_USER  = 2;
    localparam int F_KERN  = 3;
    localparam int F_ACK   = 4;
    localparam int F_ERR   = 5;
    localparam int F_PRE   = 6;
    localparam int F_BUSY  = 7;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bit   [7:0]  e_flags [N];
    bit   [31:0] e_sel   [N];
    bit   [31:0] e_off   [N];
    bit   [3:0]  e_cur   [N];
    logic [7:0]  h_flags [N];
    logic [31:0] h_sel   [N];
    logic [31:0] h_off   [N];
    logic [7:0]  act_f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctx_switch_unit_if #(.QW(QW)) bus ();

    ctx_switch_unit #(.NUM_PROC(11), .QW(QW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- timeline model ----------------
    function automatic void set_flag(input int n, input int b);
        if (n >= 0 && n < N) e_flags[n][b] = 1'b1;
    endfunction

    function automatic void model_reset(input int from);
        for (int n = from; n < N; n++) begin
            e_flags[n] = 8'h00; e_sel[n] = 32'h0; e_off[n] = 32'h0; e_cur[n] = 4'h0;
        end
    endfunction

    // Accepted request in cycle t, exit requested (inta/sys_exit) in cycle x
    function automatic void model_txn(input int t, input int pid, input logic [31:0] base,
                                      input bit lb, input int q, input int x);
        int e;
        e = t + 2 + (lb ? 1 : 0);
        for (int n = t + 1; n < N; n++) begin
            e_sel[n] = 32'(pid);
            e_cur[n] = 4'(pid);
        end
        set_flag(t + 1, F_WSEL);
        if (lb) begin
            set_flag(t + 2, F_WADDR);
            for (int n = t + 2; n < N; n++) e_off[n] = base;
        end
        set_flag(e, F_USER);
        set_flag(e, F_ACK);
        set_flag(x + 1, F_KERN);
        for (int n = t + 1; n <= x + 1; n++) set_flag(n, F_BUSY);
        if (q > 0) begin
            for (int n = e + q + 1; n <= x; n++) set_flag(n, F_PRE);
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cyc < N) begin
                act_f = {bus.busy, bus.preempt, bus.err, bus.ack,
                         bus.kernelMode, bus.userMode, bus.we_addr, bus.we_sel};
                h_flags[cyc] = act_f;
                h_sel[cyc]   = bus.sel;
                h_off[cyc]   = bus.offset;
                checks = checks + 1;
                if (act_f !== e_flags[cyc]) begin
                    errors = errors + 1;
                    $display("FAIL flags cyc=%0d got=%b exp=%b (busy,pre,err,ack,kern,user,waddr,wsel)",
                             cyc, act_f, e_flags[cyc]);
                end
                checks = checks + 1;
                if (bus.sel !== e_sel[cyc]) begin
                    errors = errors + 1;
                    $display("FAIL sel cyc=%0d got=%h exp=%h", cyc, bus.sel, e_sel[cyc]);
                end
                checks = checks + 1;
                if (bus.offset !== e_off[cyc]) begin
                    errors = errors + 1;
                    $display("FAIL offset cyc=%0d got=%h exp=%h", cyc, bus.offset, e_off[cyc]);
                end
                if (e_flags[cyc][F_BUSY]) begin
                    checks = checks + 1;
                    if (bus.cur_pid !== e_cur[cyc]) begin
                        errors = errors + 1;
                        $display("FAIL cur_pid cyc=%0d got=%0d exp=%0d", cyc, bus.cur_pid, e_cur[cyc]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset         = 1'b0;
        bus.req       = 1'b0;
        bus.pid       = 4'h0;
        bus.base      = 32'h0;
        bus.load_base = 1'b0;
        bus.quantum   = 16'h0;
        bus.inta      = 1'b0;
        bus.sys_exit  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            clr();
        end
    endtask

    // side_at: cycles after ENTER to inject an ignored req; abort_at: cycles after t to reset
    task automatic txn(input int pid, input logic [31:0] base, input bit lb, input int q,
                       input int run_len, input bit use_inta, input int side_at,
                       input int abort_at, output int t);
        int e;
        int x;
        step();
        clr();
        t = cyc;
        e = t + 2 + (lb ? 1 : 0);
        x = e + run_len;
        bus.req       = 1'b1;
        bus.pid       = 4'(pid);
        bus.base      = base;
        bus.load_base = lb;
        bus.quantum   = QW'(q);
        model_txn(t, pid, base, lb, q, x);
        while (cyc < x) begin
            step();
            clr();
            if (abort_at > 0 && cyc == t + abort_at) begin
                reset = 1'b1;
                model_reset(cyc + 1);
                return;
            end
            if (side_at > 0 && cyc == e + side_at) begin
                bus.req       = 1'b1;
                bus.pid       = 4'd1;
                bus.base      = 32'h0000_FFFF;
                bus.load_base = 1'b1;
                bus.quantum   = 16'd7;
            end
            if (cyc == x) begin
                if (use_inta) bus.inta = 1'b1;
                else          bus.sys_exit = 1'b1;
            end
        end
        step();
        clr();
    endtask

    task automatic reject(input int pid, output int t);
        step();
        clr();
        t = cyc;
        bus.req = 1'b1;
        bus.pid = 4'(pid);
        bus.base = 32'hFACE_0000;
        bus.load_base = 1'b1;
        set_flag(t + 1, F_ERR);
        step();
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit=%0d", cyc, 20000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t2;
        int cnt_a;
        int cnt_b;
        clr();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr();
        lit("rst_flags", 32'(h_flags[2]), 32'h0);
        lit("rst_sel", h_sel[2], 32'h0);
        lit("rst_offset", h_off[2], 32'h0);
        lit("rst_cur_pid", 32'(bus.cur_pid), 32'h0);
        idle(2);

        // Full sequence with base load and quantum 5
        txn(3, 32'h0000_0400, 1'b1, 5, 8, 1'b1, 0, 0, t);
        idle(2);
        lit("s1_sel_T1", h_sel[t + 1], 32'd3);
        lit("s1_wsel_T1", 32'(h_flags[t + 1][F_WSEL]), 32'd1);
        lit("s1_off_T2", h_off[t + 2], 32'h400);
        lit("s1_waddr_T2", 32'(h_flags[t + 2][F_WADDR]), 32'd1);
        lit("s1_user_ack_T3", 32'({h_flags[t + 3][F_USER], h_flags[t + 3][F_ACK]}), 32'd3);
        lit("s1_pre_T8", 32'(h_flags[t + 8][F_PRE]), 32'd0);
        lit("s1_pre_T9", 32'(h_flags[t + 9][F_PRE]), 32'd1);
        lit("s1_kern_T12", 32'(h_flags[t + 12][F_KERN]), 32'd1);

        // No base load, no preemption, 1000 cycles then sys_exit
        txn(2, 32'hDEAD_BEEF, 1'b0, 0, 1000, 1'b0, 0, 0, t);
        idle(3);
        cnt_a = 0;
        cnt_b = 0;
        for (int n = t + 1; n <= t + 1004; n++) begin
            cnt_a += int'(h_flags[n][F_WADDR]);
            cnt_b += int'(h_flags[n][F_PRE]);
        end
        lit("s2_user_T2", 32'(h_flags[t + 2][F_USER]), 32'd1);
        lit("s2_no_waddr", 32'(cnt_a), 32'd0);
        lit("s2_no_preempt", 32'(cnt_b), 32'd0);
        lit("s2_offset_kept", h_off[t + 500], 32'h400);
        lit("s2_kern", 32'(h_flags[t + 1003][F_KERN]), 32'd1);
        lit("s2_busy_after", 32'(h_flags[t + 1004][F_BUSY]), 32'd0);

        // Out-of-range slots, then inta while idle
        reject(11, t);
        reject(15, t2);
        idle(2);
        lit("s3_err_only", 32'(h_flags[t + 1]), 32'h20);
        lit("s3_err15", 32'(h_flags[t2 + 1]), 32'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            clr();
            bus.inta = 1'b1;
            bus.sys_exit = (i == 1);
        end
        idle(2);

        // inta on the expiry cycle wins over preempt
        txn(5, 32'h1234_5678, 1'b1, 4, 4, 1'b1, 0, 0, t);
        idle(2);
        cnt_b = 0;
        for (int n = t; n <= t + 9; n++) cnt_b += int'(h_flags[n][F_PRE]);
        lit("s5_no_preempt", 32'(cnt_b), 32'd0);
        lit("s5_kern", 32'(h_flags[t + 8][F_KERN]), 32'd1);

        // req during RUN ignored; preempt held until inta
        txn(7, 32'hABCD_0000, 1'b1, 3, 10, 1'b1, 2, 0, t);
        idle(2);
        lit("s6_sel_kept", h_sel[t + 6], 32'd7);
        lit("s6_pre_held", 32'(h_flags[t + 13][F_PRE]), 32'd1);
        lit("s6_pre_clr", 32'(h_flags[t + 14][F_PRE]), 32'd0);
        lit("s6_kern", 32'(h_flags[t + 14][F_KERN]), 32'd1);

        // Reset in BASE, then an immediate request for the highest slot
        txn(4, 32'h0000_0800, 1'b1, 2, 20, 1'b1, 0, 2, t);
        txn(10, 32'h0000_0010, 1'b0, 1, 3, 1'b0, 0, 0, t2);
        idle(2);
        lit("s7_rst_flags", 32'(h_flags[t + 3]), 32'h0);
        lit("s7_rst_sel", h_sel[t + 3], 32'h0);
        lit("s7_rst_off", h_off[t + 3], 32'h0);
        lit("s7_next_sel", h_sel[t2 + 1], 32'd10);
        lit("s7_next_pre", 32'(h_flags[t2 + 4][F_PRE]), 32'd1);

        // Reset in RUN with preempt pending, then one more sequence
        txn(1, 32'h0000_2000, 1'b1, 1, 30, 1'b1, 0, 8, t);
        idle(2);
        lit("s8_pre_before", 32'(h_flags[t + 8][F_PRE]), 32'd1);
        lit("s8_rst_flags", 32'(h_flags[t + 9]), 32'h0);
        txn(0, 32'h0000_3000, 1'b1, 2, 3, 1'b0, 0, 0, t);
        idle(3);
        lit("s8_final_off", h_off[t + 2], 32'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
